// File: rtl/sram_mem_controller.sv
// sram_mem_controller: runs 32-bit word reads/writes (addr/wdata/rd_req/wr_req -> rdata/sram_stalled/done) on a 16-bit async SRAM (sram_*) as low then high half-word phases
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [31:0]       rdata,
  output logic              sram_stalled,
  output logic              done,
  output logic [ADDR_W:0]   sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
  localparam logic [3:0] W = 4'(WAIT_CYCLES);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_lat;
  logic [31:0] wdata_lat;
  logic rd, wr, hi, last;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    rd = state == RD_LO || state == RD_HI;
    wr = state == WR_LO || state == WR_HI;
    hi = state == RD_HI || state == WR_HI;
    last = cnt == W;
    state_n = state;
    case (state)
      IDLE:    state_n = wr_req ? WR_LO : rd_req ? RD_LO : IDLE;
      RD_LO:   state_n = last ? RD_HI : RD_LO;
      RD_HI:   state_n = last ? DONE : RD_HI;
      WR_LO:   state_n = last ? WR_HI : WR_LO;
      WR_HI:   state_n = last ? DONE : WR_HI;
      default: state_n = IDLE;
    endcase
    sram_ce_n = !(rd || wr);
    sram_ub_n = !(rd || wr);
    sram_lb_n = !(rd || wr);
    sram_oe_n = !rd;
    sram_we_n = !(wr && (!last || W == 4'd0));
    sram_dq_oe = wr;
    sram_dq_out = wr ? (hi ? wdata_lat[31:16] : wdata_lat[15:0]) : 16'h0;
    sram_addr = {addr_lat, hi};
    done = state == DONE;
    sram_stalled = (rd || wr) || (state == IDLE && (rd_req || wr_req));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= 4'd0;
      addr_lat <= '0;
      wdata_lat <= 32'h0;
      rdata <= 32'h0;
    end else begin
      cnt <= ((rd || wr) && !last) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && (rd_req || wr_req)) addr_lat <= addr;
      if (state == IDLE && wr_req) wdata_lat <= wdata;
      if (rd && last && hi) rdata[31:16] <= sram_dq_in;
      if (rd && last && !hi) rdata[15:0] <= sram_dq_in;
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: directed and randomized checks of sram_mem_controller at WAIT_CYCLES 0, 1 and 3 against a per-transaction schedule model
module tb_sram_mem_controller;
  logic clk = 0, reset = 1, rd_req = 0, wr_req = 0;
  logic [16:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [15:0] dq_in = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int W = g == 0 ? 0 : g == 1 ? 1 : 3;
    localparam int P = W + 1;
    logic [31:0] rdata;
    logic [17:0] sa;
    logic [15:0] dq_out;
    logic stalled, done, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
    int k;
    logic op_wr, hi, last;
    logic [16:0] ma;
    logic [31:0] mw, mr;
    logic [7:0] e;
    sram_mem_controller #(.WAIT_CYCLES(W), .ADDR_W(17)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rd_req(rd_req), .wr_req(wr_req),
      .rdata(rdata), .sram_stalled(stalled), .done(done), .sram_addr(sa), .sram_dq_out(dq_out),
      .sram_dq_in(dq_in), .sram_dq_oe(dq_oe), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
      .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n));
    // k counts cycles since the request was accepted: 1..P low phase, P+1..2P high phase, 2P+1 done
    initial begin
      k = 0; op_wr = 0; ma = '0; mw = '0; mr = '0;
      forever begin
        @(negedge clk);
        if (reset) begin k = 0; mr = '0; end
        hi = k > P;
        last = (k - 1) % P == W;
        if (k == 0) e = {5'b11111, 2'b00, rd_req | wr_req};
        else if (k == 2 * P + 1) e = 8'b11111_010;
        else if (op_wr) e = {2'b01, (last && W != 0), 5'b00101};
        else e = 8'b00100_001;
        chk($sformatf("w%0d_ctl", W), {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, done, stalled}, e);
        chk($sformatf("w%0d_rdata", W), rdata, mr);
        if (reset) begin
          chk($sformatf("w%0d_rst_addr", W), sa, 0);
          chk($sformatf("w%0d_rst_dq_out", W), dq_out, 0);
        end else if (k >= 1 && k <= 2 * P) begin
          chk($sformatf("w%0d_addr", W), sa, {ma, hi});
          if (op_wr) chk($sformatf("w%0d_dq_out", W), dq_out, hi ? mw[31:16] : mw[15:0]);
        end
        @(posedge clk);
        if (reset) begin
          k = 0; mr = '0;
        end else if (k == 0) begin
          if (rd_req | wr_req) begin k = 1; op_wr = wr_req; ma = addr; mw = wdata; end
        end else begin
          if (!op_wr && k <= 2 * P && (k - 1) % P == W) begin
            if (k > P) mr[31:16] = dq_in;
            else mr[15:0] = dq_in;
          end
          k = k == 2 * P + 1 ? 0 : k + 1;
        end
      end
    end
  end
  initial begin
    #1;
    chk("rst_rdata", u[1].rdata, 0);
    chk("rst_addr", u[1].sa, 0);
    chk("rst_strobes", {u[1].ce_n, u[1].oe_n, u[1].we_n, u[1].ub_n, u[1].lb_n, u[1].dq_oe, u[1].done}, 7'b1111100);
    cyc(2);
    reset = 0;
    cyc(2);
    addr = 17'h00005; rd_req = 1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 1) rd_req = 0;
      dq_in = c <= 2 ? 16'hBEEF : 16'hDEAD;
      @(negedge clk);
      chk("rd_stall", u[1].stalled, c < 5);
      chk("rd_done", u[1].done, c == 5);
      if (c >= 1 && c <= 4) chk("rd_addr", u[1].sa, c <= 2 ? 18'h0000A : 18'h0000B);
      if (c == 5) chk("rd_word", u[1].rdata, 32'hDEADBEEF);
      cyc(1);
    end
    cyc(12);
    addr = 17'h1FFFF; wdata = 32'h12345678; wr_req = 1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 1) wr_req = 0;
      @(negedge clk);
      chk("wr_done", u[1].done, c == 5);
      chk("wr_rdata_kept", u[1].rdata, 32'hDEADBEEF);
      if (c >= 1 && c <= 4) begin
        chk("wr_addr", u[1].sa, c <= 2 ? 18'h3FFFE : 18'h3FFFF);
        chk("wr_dq_out", u[1].dq_out, c <= 2 ? 16'h5678 : 16'h1234);
        chk("wr_we_n", u[1].we_n, c == 2 || c == 4);
      end
      cyc(1);
    end
    cyc(12);
    addr = 17'h00123; wdata = 32'hCAFEF00D; rd_req = 1; wr_req = 1;
    for (int c = 0; c <= 3; c++) begin
      if (c == 1) begin rd_req = 0; wr_req = 0; end
      @(negedge clk);
      chk("w0_both_oe_n", u[0].oe_n, 1);
      chk("w0_both_done", u[0].done, c == 3);
      if (c >= 1 && c <= 2) begin
        chk("w0_both_we_n", u[0].we_n, 0);
        chk("w0_both_dq_out", u[0].dq_out, c == 1 ? 16'hF00D : 16'hCAFE);
      end
      cyc(1);
    end
    cyc(12);
    addr = 17'h0ABCD; rd_req = 1;
    for (int c = 0; c <= 9; c++) begin
      if (c == 2) rd_req = 0;
      dq_in = 16'($urandom);
      @(negedge clk);
      chk("w3_drop_stall", u[2].stalled, c < 9);
      chk("w3_drop_done", u[2].done, c == 9);
      cyc(1);
    end
    cyc(12);
    addr = 17'h00042; rd_req = 1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 7) rd_req = 0;
      dq_in = 16'($urandom);
      @(negedge clk);
      chk("b2b_done", u[1].done, c == 5 || c == 11);
      if (c == 6) chk("b2b_restall", u[1].stalled, 1);
      cyc(1);
    end
    cyc(12);
    addr = 17'h00777; wdata = 32'h0BADCAFE; wr_req = 1;
    cyc(1);
    wr_req = 0;
    #1;
    chk("mid_we_n_low", u[1].we_n, 0);
    #1;
    reset = 1;
    #1;
    chk("mid_rst_strobes", {u[1].ce_n, u[1].oe_n, u[1].we_n, u[1].ub_n, u[1].lb_n, u[1].dq_oe, u[1].done}, 7'b1111100);
    chk("mid_rst_rdata", u[1].rdata, 0);
    cyc(1);
    reset = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mid_rst_no_done", u[1].done, 0);
      cyc(1);
    end
    for (int i = 0; i < 3000; i++) begin
      rd_req = $urandom_range(0, 2) == 0;
      wr_req = $urandom_range(0, 3) == 0;
      addr = $urandom_range(0, 7) == 0 ? 17'h1FFFF : 17'($urandom);
      wdata = $urandom;
      dq_in = 16'($urandom);
      reset = $urandom_range(0, 299) == 0;
      cyc(1);
    end
    rd_req = 0; wr_req = 0; reset = 0;
    cyc(12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
